// File: rtl/ramp_calibrator_if.sv
// rtl/ramp_calibrator_if.sv - control, receiver and DAC-side signals of the ramp calibrator
interface ramp_calibrator_if #(
  parameter int VW = 8,
  parameter int CW = 2
);
  logic          start;
  logic          abort;
  logic [1:0]    mode;
  logic [VW-1:0] start_voltage;
  logic          noise_valid;
  logic [VW-1:0] voltage;
  logic          spi_start;
  logic          varu;
  logic          done;
  logic          fail;
  logic [CW-1:0] win_count;
  logic [3:0]    state_dbg;

  modport master (
    output start, abort, mode, start_voltage, noise_valid,
    input  voltage, spi_start, varu, done, fail, win_count, state_dbg
  );

  modport slave (
    input  start, abort, mode, start_voltage, noise_valid,
    output voltage, spi_start, varu, done, fail, win_count, state_dbg
  );
endinterface

// File: rtl/ramp_calibrator.sv
// rtl/ramp_calibrator.sv - bias-voltage ramp search for the noise threshold with back-off and hold
module ramp_calibrator #(
  parameter int VW       = 8,
  parameter int TW       = 16,
  parameter int INIT_T   = 4,
  parameter int SEND_T   = 4,
  parameter int INC_T    = 2,
  parameter int PAUSE_T  = 2,
  parameter int LISTEN_T = 8,
  parameter int NUM_WIN  = 3,
  parameter int STEP     = 1,
  parameter int BACKOFF  = 2
) (
  input logic             clk,
  input logic             reset,
  ramp_calibrator_if.slave bus
);
  localparam int CW = $clog2(NUM_WIN + 1);
  localparam logic [CW-1:0] NW = CW'(NUM_WIN);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_INIT     = 4'd1,
    S_TRANSMIT = 4'd2,
    S_STEP     = 4'd3,
    S_PAUSE    = 4'd4,
    S_LISTEN   = 4'd5,
    S_BACKOFF  = 4'd6,
    S_HOLD     = 4'd7,
    S_FAIL     = 4'd8
  } state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tmr;
  logic [VW-1:0] volt, volt_nx;
  logic [CW-1:0] wc, wc_nx;
  logic          mode_dn, have_prev, prev_noisy, nflag;
  logic          spi_start, varu, done, fail;
  logic          noisy, qualify, do_step, step_ovf, last;
  logic [VW:0]   step_sum, step_diff, bo_sum, bo_diff;

  function automatic logic [TW-1:0] dur(input state_t s);
    case (s)
      S_INIT:     dur = TW'(INIT_T - 1);
      S_TRANSMIT: dur = TW'(SEND_T - 1);
      S_STEP:     dur = TW'(INC_T - 1);
      S_PAUSE:    dur = TW'(PAUSE_T - 1);
      S_LISTEN:   dur = TW'(LISTEN_T - 1);
      default:    dur = '0;
    endcase
  endfunction

  always_comb begin
    state_nx  = state;
    volt_nx   = volt;
    wc_nx     = wc;
    last      = (tmr == dur(state));
    noisy     = nflag | bus.noise_valid;
    qualify   = mode_dn ? !noisy : noisy;
    step_sum  = {1'b0, volt} + (VW+1)'(STEP);
    step_diff = {1'b0, volt} - (VW+1)'(STEP);
    bo_sum    = {1'b0, volt} + (VW+1)'(BACKOFF);
    bo_diff   = {1'b0, volt} - (VW+1)'(BACKOFF);
    // STEP reacts to the previous window; the first window after INIT has none
    do_step   = have_prev && (mode_dn ? prev_noisy : !prev_noisy);
    step_ovf  = do_step && (mode_dn ? step_diff[VW] : step_sum[VW]);
    case (state)
      S_IDLE, S_HOLD, S_FAIL: begin
        if (bus.start) begin
          state_nx = S_INIT;
          volt_nx  = bus.start_voltage;
          wc_nx    = '0;
        end
      end
      S_INIT:     if (last) state_nx = S_TRANSMIT;
      S_TRANSMIT: if (last) state_nx = S_STEP;
      S_STEP: begin
        if (last) begin
          if (step_ovf) begin
            state_nx = S_FAIL;
          end else begin
            state_nx = S_PAUSE;
            if (do_step) volt_nx = mode_dn ? step_diff[VW-1:0] : step_sum[VW-1:0];
          end
        end
      end
      S_PAUSE:    if (last) state_nx = S_LISTEN;
      S_LISTEN: begin
        if (last) begin
          if (qualify) wc_nx = (wc == NW) ? wc : wc + 1'b1;
          else         wc_nx = '0;
          state_nx = (wc_nx == NW) ? S_BACKOFF : S_TRANSMIT;
        end
      end
      S_BACKOFF: begin
        state_nx = S_HOLD;
        if (mode_dn) volt_nx = bo_sum[VW] ? '1 : bo_sum[VW-1:0];
        else         volt_nx = bo_diff[VW] ? '0 : bo_diff[VW-1:0];
      end
      default:    state_nx = S_IDLE;
    endcase
    if (bus.abort) begin
      state_nx = S_IDLE;
      volt_nx  = '0;
      wc_nx    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      tmr        <= '0;
      volt       <= '0;
      wc         <= '0;
      mode_dn    <= 1'b0;
      have_prev  <= 1'b0;
      prev_noisy <= 1'b0;
      nflag      <= 1'b0;
      spi_start  <= 1'b0;
      varu       <= 1'b1;
      done       <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state <= state_nx;
      volt  <= volt_nx;
      wc    <= wc_nx;
      tmr   <= (state_nx != state) ? '0 : tmr + 1'b1;
      if (state == S_LISTEN) begin
        if (last) begin
          nflag      <= 1'b0;
          prev_noisy <= noisy;
          have_prev  <= 1'b1;
        end else begin
          nflag <= noisy;
        end
      end
      // INIT is only ever entered from an accepted start
      if (state_nx == S_INIT && state != S_INIT) begin
        mode_dn   <= (bus.mode == 2'b01);
        have_prev <= 1'b0;
        nflag     <= 1'b0;
      end
      spi_start <= (state_nx == S_TRANSMIT);
      varu      <= (state_nx == S_HOLD);
      done      <= (state_nx == S_HOLD);
      fail      <= (state_nx == S_FAIL);
    end
  end

  assign bus.voltage   = volt;
  assign bus.spi_start = spi_start;
  assign bus.varu      = varu;
  assign bus.done      = done;
  assign bus.fail      = fail;
  assign bus.win_count = wc;
  assign bus.state_dbg = state;
endmodule

// File: tb/tb_ramp_calibrator.sv
// tb/tb_ramp_calibrator.sv - scoreboard bench for ramp_calibrator searches, limits, abort and reset
module tb_ramp_calibrator;
  localparam int VW = 8;
  localparam int CW = 2;
  localparam int INIT_T = 4;
  localparam int SEND_T = 4;
  localparam int LISTEN_T = 8;
  localparam int P_NONE = 0, P_THR = 1, P_THR_DN = 2, P_MASK = 3, P_LAST = 4, P_PAUSE = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ramp_calibrator_if #(.VW(VW), .CW(CW)) bus ();

  ramp_calibrator #(.VW(VW), .NUM_WIN(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int policy = P_NONE;
  int thr = 0;
  logic [7:0] mask = '0;
  int lcnt = 0;
  int win_idx = 0;
  logic [3:0] prev_st = '0;
  logic [VW-1:0] exp_v[$];
  logic [CW-1:0] exp_wc[$];

  // Advance one cycle, flag LISTEN entry/exit and drive noise for the cycle now showing
  task automatic tick(output bit li, output bit lo);
    @(negedge clk);
    cyc++;
    li = (bus.state_dbg == 4'd5) && (prev_st != 4'd5);
    lo = (bus.state_dbg != 4'd5) && (prev_st == 4'd5);
    if (li) begin
      lcnt = 0;
      win_idx++;
    end else if (bus.state_dbg == 4'd5) begin
      lcnt++;
    end
    prev_st = bus.state_dbg;
    case (policy)
      P_THR:    bus.noise_valid = (bus.state_dbg == 4'd5) && (lcnt == 3) && (int'(bus.voltage) >= thr);
      P_THR_DN: bus.noise_valid = (int'(bus.voltage) >= thr);
      P_MASK:   bus.noise_valid = (bus.state_dbg == 4'd5) && (lcnt == 0) && mask[win_idx[2:0]];
      P_LAST:   bus.noise_valid = (bus.state_dbg == 4'd5) && (lcnt == LISTEN_T - 1);
      P_PAUSE:  bus.noise_valid = (bus.state_dbg == 4'd4);
      default:  bus.noise_valid = 1'b0;
    endcase
  endtask

  task automatic kick(input logic [1:0] m, input logic [VW-1:0] v);
    bit a, b;
    win_idx = 0;
    bus.mode = m;
    bus.start_voltage = v;
    bus.start = 1'b1;
    tick(a, b);
    bus.start = 1'b0;
  endtask

  task automatic do_abort();
    bit a, b;
    bus.abort = 1'b1;
    tick(a, b);
    bus.abort = 1'b0;
  endtask

  task automatic test_reset();
    bit a, b;
    reset = 1'b1;
    repeat (3) tick(a, b);
    vectors++;
    if ({bus.voltage, bus.spi_start, bus.varu, bus.done, bus.fail, bus.win_count, bus.state_dbg} !==
        {8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0}) begin
      miscompares++;
      $display("FAIL reset_values got v=%0d spi=%b varu=%b done=%b fail=%b wc=%0d st=%0d want 0/0/1/0/0/0/0",
               bus.voltage, bus.spi_start, bus.varu, bus.done, bus.fail, bus.win_count, bus.state_dbg);
    end
    reset = 1'b0;
    tick(a, b);
    vectors++;
    if (bus.varu !== 1'b0) begin
      miscompares++;
      $display("FAIL varu_after_reset got %b want 0", bus.varu);
    end
  endtask

  task automatic test_search(input string name, input logic [1:0] m, input logic [VW-1:0] sv,
                             input int pol, input int th, input logic [7:0] mk, input logic [VW-1:0] hold_v);
    bit li, lo, fin;
    int spi_run, last_l, kick_c, first_spi, hold_c;
    logic [VW-1:0] ev;
    logic [CW-1:0] ew;
    policy = pol; thr = th; mask = mk;
    fin = 0; spi_run = 0; last_l = 0; first_spi = -1; hold_c = 0;
    kick(m, sv);
    kick_c = cyc;
    for (int c = 0; c < 400 && !fin; c++) begin
      tick(li, lo);
      if (bus.spi_start === 1'b1) begin
        spi_run++;
        if (first_spi < 0) first_spi = cyc - kick_c;
      end else if (spi_run != 0) begin
        vectors++;
        if (spi_run != SEND_T) begin
          miscompares++;
          $display("FAIL %s spi_width got %0d want %0d", name, spi_run, SEND_T);
        end
        spi_run = 0;
      end
      if (li) begin
        vectors++;
        if (exp_v.size() == 0) begin
          miscompares++;
          $display("FAIL %s extra_window at voltage %0d", name, bus.voltage);
        end else begin
          ev = exp_v.pop_front();
          if (bus.voltage !== ev) begin
            miscompares++;
            $display("FAIL %s listen_voltage got %0d want %0d", name, bus.voltage, ev);
          end
        end
      end
      if (lo && exp_wc.size() != 0) begin
        ew = exp_wc.pop_front();
        vectors++;
        if (bus.win_count !== ew) begin
          miscompares++;
          $display("FAIL %s win_count got %0d want %0d", name, bus.win_count, ew);
        end
      end
      if (bus.state_dbg == 4'd5) last_l = cyc;
      if (bus.state_dbg == 4'd7) begin
        fin = 1;
        hold_c = cyc;
      end
    end
    vectors++;
    if (!fin) begin
      miscompares++;
      $display("FAIL %s hold_timeout got state %0d want 7", name, bus.state_dbg);
    end
    vectors++;
    if (first_spi != INIT_T) begin
      miscompares++;
      $display("FAIL %s spi_latency got %0d want %0d", name, first_spi, INIT_T);
    end
    vectors++;
    if (hold_c - last_l != 2) begin
      miscompares++;
      $display("FAIL %s done_latency got %0d want 2", name, hold_c - last_l);
    end
    vectors++;
    if ({bus.done, bus.varu, bus.fail, bus.voltage, bus.win_count} !== {1'b1, 1'b1, 1'b0, hold_v, 2'd3}) begin
      miscompares++;
      $display("FAIL %s hold got done=%b varu=%b fail=%b v=%0d wc=%0d want 1/1/0/%0d/3",
               name, bus.done, bus.varu, bus.fail, bus.voltage, bus.win_count, hold_v);
    end
    vectors++;
    if (exp_v.size() != 0 || exp_wc.size() != 0) begin
      miscompares++;
      $display("FAIL %s missing_windows got %0d left want 0", name, exp_v.size() + exp_wc.size());
    end
    exp_v.delete();
    exp_wc.delete();
  endtask

  task automatic test_overflow();
    bit li, lo, fin;
    logic [VW-1:0] ev;
    policy = P_NONE;
    fin = 0;
    exp_v = '{8'd254, 8'd255};
    kick(2'b00, 8'd254);
    for (int c = 0; c < 200 && !fin; c++) begin
      tick(li, lo);
      if (li) begin
        vectors++;
        ev = (exp_v.size() != 0) ? exp_v.pop_front() : 8'hxx;
        if (bus.voltage !== ev) begin
          miscompares++;
          $display("FAIL overflow_listen got %0d want %0d", bus.voltage, ev);
        end
      end
      if (bus.state_dbg == 4'd8) fin = 1;
    end
    vectors++;
    if (!fin || {bus.fail, bus.done, bus.varu, bus.voltage} !== {1'b1, 1'b0, 1'b0, 8'd255}) begin
      miscompares++;
      $display("FAIL overflow_fail got st=%0d fail=%b done=%b varu=%b v=%0d want 8/1/0/0/255",
               bus.state_dbg, bus.fail, bus.done, bus.varu, bus.voltage);
    end
    exp_v.delete();
  endtask

  task automatic test_noise_window();
    bit li, lo;
    int nlo, nli;
    do_abort();
    policy = P_LAST;
    kick(2'b00, 8'd50);
    nlo = 0;
    for (int c = 0; c < 100 && nlo == 0; c++) begin
      tick(li, lo);
      if (lo) nlo++;
    end
    vectors++;
    if (nlo == 0 || bus.win_count !== 2'd1) begin
      miscompares++;
      $display("FAIL last_cycle_noise got wc=%0d seen=%0d want 1", bus.win_count, nlo);
    end
    do_abort();
    policy = P_PAUSE;
    kick(2'b00, 8'd50);
    nlo = 0; nli = 0;
    for (int c = 0; c < 100 && nli < 2; c++) begin
      tick(li, lo);
      if (li) nli++;
      if (lo) begin
        nlo++;
        vectors++;
        if (bus.win_count !== 2'd0) begin
          miscompares++;
          $display("FAIL pause_noise_wc got %0d want 0", bus.win_count);
        end
      end
    end
    vectors++;
    if (nli < 2 || bus.voltage !== 8'd51) begin
      miscompares++;
      $display("FAIL pause_noise_step got v=%0d windows=%0d want 51", bus.voltage, nli);
    end
    policy = P_NONE;
  endtask

  task automatic test_abort_reset();
    bit li, lo, found;
    do_abort();
    policy = P_NONE;
    kick(2'b00, 8'd30);
    found = 0;
    for (int c = 0; c < 200 && !found; c++) begin
      tick(li, lo);
      if (bus.state_dbg == 4'd5 && lcnt == 3) found = 1;
    end
    vectors++;
    if (!found || bus.voltage !== 8'd30) begin
      miscompares++;
      $display("FAIL abort_setup got st=%0d v=%0d want 5/30", bus.state_dbg, bus.voltage);
    end
    bus.abort = 1'b1;
    bus.start = 1'b1;
    bus.start_voltage = 8'd99;
    tick(li, lo);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    vectors++;
    if ({bus.state_dbg, bus.voltage, bus.spi_start, bus.win_count} !== {4'd0, 8'd0, 1'b0, 2'd0}) begin
      miscompares++;
      $display("FAIL abort_start got st=%0d v=%0d spi=%b wc=%0d want 0/0/0/0",
               bus.state_dbg, bus.voltage, bus.spi_start, bus.win_count);
    end
    kick(2'b00, 8'd30);
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      tick(li, lo);
      if (bus.spi_start === 1'b1) found = 1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL reset_setup got spi=%b want 1", bus.spi_start);
    end
    reset = 1'b1;
    tick(li, lo);
    vectors++;
    if ({bus.voltage, bus.spi_start, bus.varu, bus.done, bus.fail, bus.win_count, bus.state_dbg} !==
        {8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 4'd0}) begin
      miscompares++;
      $display("FAIL reset_mid got v=%0d spi=%b varu=%b done=%b fail=%b wc=%0d st=%0d want 0/0/1/0/0/0/0",
               bus.voltage, bus.spi_start, bus.varu, bus.done, bus.fail, bus.win_count, bus.state_dbg);
    end
    reset = 1'b0;
    tick(li, lo);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.mode = 2'b00;
    bus.start_voltage = '0;
    bus.noise_valid = 1'b0;
    test_reset();
    exp_v = '{8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd14, 8'd14};
    exp_wc = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    test_search("up", 2'b00, 8'd10, P_THR, 14, 8'h00, 8'd12);
    exp_v = '{8'd20, 8'd19, 8'd18, 8'd17, 8'd16, 8'd16, 8'd16};
    exp_wc = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};
    test_search("down", 2'b01, 8'd20, P_THR_DN, 17, 8'h00, 8'd18);
    exp_v = '{8'd10, 8'd10, 8'd10, 8'd11, 8'd11, 8'd11};
    exp_wc = '{2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};
    test_search("streak", 2'b10, 8'd10, P_MASK, 0, 8'b0111_0110, 8'd9);
    test_overflow();
    test_noise_window();
    test_abort_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
